serial_receiver: RTL and testbench

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver.sv | 191 +++++++++++++++++++
 tb/tb_serial_receiver.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// Oversampled asynchronous serial receiver.
// The line is synchronized, a start bit is confirmed at its midpoint, and every following
// bit is sampled once per bit period. Results are handed to the consumer through a
// data_valid / char_ack handshake with a sticky overrun flag.
module serial_receiver #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 serial_in,
   input  logic                 char_ack,
   output logic [DATA_BITS-1:0] parallel_out,
   output logic                 char_received,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   // scnt peaks at OVERSAMPLE-1; bcnt peaks at DATA_BITS-1 (stop bits reuse it)
   localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BCNT_W = $clog2(DATA_BITS);

   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
   localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BCNT_W-1:0] BCNT_DATA = BCNT_W'(DATA_BITS - 1);
   localparam logic [BCNT_W-1:0] BCNT_STOP = BCNT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e               r_state;
   logic [1:0]           r_sync;
   logic [SCNT_W-1:0]    r_scnt;
   logic [BCNT_W-1:0]    r_bcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_wait_high;
   logic [DATA_BITS-1:0] r_parallel_out;
   logic                 r_char_received;
   logic                 r_data_valid;
   logic                 r_frame_err;
   logic                 r_parity_err;
   logic                 r_overrun;

   logic w_rx;
   logic w_stop_bad;
   logic w_par_bad;

   assign w_rx       = r_sync[1];
   // accumulated frame error including the stop bit sampled on this tick
   assign w_stop_bad = r_ferr | ~w_rx;
   assign w_par_bad  = ((^r_shift) ^ w_rx) != 1'(PARITY_ODD);

   assign parallel_out  = r_parallel_out;
   assign char_received = r_char_received;
   assign data_valid    = r_data_valid;
   assign frame_err     = r_frame_err;
   assign parity_err    = r_parity_err;
   assign overrun       = r_overrun;

   // Two-flop synchronizer for the asynchronous line, idling high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], serial_in};
      end
   end

   // Receive FSM with bit timing, error tracking and the consumer handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= StIdle;
         r_scnt          <= '0;
         r_bcnt          <= '0;
         r_shift         <= '0;
         r_perr          <= 1'b0;
         r_ferr          <= 1'b0;
         r_wait_high     <= 1'b0;
         r_parallel_out  <= '0;
         r_char_received <= 1'b0;
         r_data_valid    <= 1'b0;
         r_frame_err     <= 1'b0;
         r_parity_err    <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         r_char_received <= 1'b0;

         // a completion later in this block overrides the acknowledge
         if (char_ack) begin
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
         end

         // after a framing error the line must go idle before a new start is searched
         if (r_state == StIdle && r_wait_high && w_rx) begin
            r_wait_high <= 1'b0;
         end

         if (tick) begin
            unique case (r_state)
               StIdle: begin
                  if (!r_wait_high && !w_rx) begin
                     r_state <= StStart;
                     r_scnt  <= '0;
                  end
               end

               StStart: begin
                  if (r_scnt == SCNT_HALF) begin
                     if (!w_rx) begin
                        r_state <= StData;
                        r_scnt  <= '0;
                        r_bcnt  <= '0;
                     end else begin
                        r_state <= StIdle;
                     end
                  end else begin
                     r_scnt <= r_scnt + SCNT_W'(1);
                  end
               end

               StData: begin
                  if (r_scnt == SCNT_LAST) begin
                     for (int unsigned i = 0; i < DATA_BITS; i++) begin
                        if (r_bcnt == BCNT_W'(i)) begin
                           r_shift[i] <= w_rx;
                        end
                     end
                     r_scnt <= '0;
                     if (r_bcnt == BCNT_DATA) begin
                        r_bcnt  <= '0;
                        r_state <= (PARITY_EN != 0) ? StParity : StStop;
                     end else begin
                        r_bcnt <= r_bcnt + BCNT_W'(1);
                     end
                  end else begin
                     r_scnt <= r_scnt + SCNT_W'(1);
                  end
               end

               StParity: begin
                  if (r_scnt == SCNT_LAST) begin
                     r_perr  <= w_par_bad;
                     r_scnt  <= '0;
                     r_bcnt  <= '0;
                     r_state <= StStop;
                  end else begin
                     r_scnt <= r_scnt + SCNT_W'(1);
                  end
               end

               StStop: begin
                  if (r_scnt == SCNT_LAST) begin
                     r_scnt <= '0;
                     if (r_bcnt == BCNT_STOP) begin
                        r_parallel_out  <= r_shift;
                        r_frame_err     <= w_stop_bad;
                        r_parity_err    <= (PARITY_EN != 0) ? r_perr : 1'b0;
                        r_char_received <= 1'b1;
                        r_data_valid    <= 1'b1;
                        if (r_data_valid && !char_ack) begin
                           r_overrun <= 1'b1;
                        end
                        r_wait_high <= w_stop_bad;
                        r_ferr      <= 1'b0;
                        r_perr      <= 1'b0;
                        r_bcnt      <= '0;
                        r_state     <= StIdle;
                     end else begin
                        r_ferr <= w_stop_bad;
                        r_bcnt <= r_bcnt + BCNT_W'(1);
                     end
                  end else begin
                     r_scnt <= r_scnt + SCNT_W'(1);
                  end
               end

               default: r_state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: two instances (default framing, and 7 data bits with
// even parity and two stop bits) driven by a frame generator; a monitor per instance checks
// each delivered character against expectations queued when the frame was sent.
`timescale 1ns/1ps
module tb_serial_receiver;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       ovr;
      int         fall;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic line0 = 1'b1;
   logic line1 = 1'b1;
   logic ack0 = 1'b0;
   logic ack1 = 1'b0;
   logic tick;
   int   tick_div = 1;
   int   tick_cnt = 0;
   int   cyc = 0;

   logic [7:0] po0;
   logic       cr0, dv0, fe0, pe0, ov0;
   logic [6:0] po1;
   logic       cr1, dv1, fe1, pe1, ov1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   npulse0 = 0;
   int   npulse1 = 0;
   bit   model_dv[2];
   bit   model_ovr[2];
   int   fall_cyc[2];
   bit   fall_seen[2];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tick_cnt <= (tick_cnt >= tick_div - 1) ? 0 : tick_cnt + 1;
      cyc      <= cyc + 1;
   end
   assign tick = (tick_cnt == 0);

   serial_receiver u_dut_a (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .serial_in    (line0),
      .char_ack     (ack0),
      .parallel_out (po0),
      .char_received(cr0),
      .data_valid   (dv0),
      .frame_err    (fe0),
      .parity_err   (pe0),
      .overrun      (ov0)
   );

   serial_receiver #(
      .DATA_BITS (7),
      .OVERSAMPLE(8),
      .PARITY_EN (1),
      .PARITY_ODD(0),
      .STOP_BITS (2)
   ) u_dut_b (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .serial_in    (line1),
      .char_ack     (ack1),
      .parallel_out (po1),
      .char_received(cr1),
      .data_valid   (dv1),
      .frame_err    (fe1),
      .parity_err   (pe1),
      .overrun      (ov1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic [8:0] po, input logic fe, input logic pe,
                      input logic ov, input logic dv);
      exp_t e;
      if (d == 0) npulse0++;
      else npulse1++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         n_vec++;
         n_err++;
         $display("FAIL dut%0d unexpected char: got data 0x%0h, want no character", d, po);
         return;
      end
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("dut%0d data", d), 32'(po), 32'(e.data));
      chk($sformatf("dut%0d frame_err", d), 32'(fe), 32'(e.ferr));
      chk($sformatf("dut%0d parity_err", d), 32'(pe), 32'(e.perr));
      chk($sformatf("dut%0d overrun", d), 32'(ov), 32'(e.ovr));
      chk($sformatf("dut%0d data_valid", d), 32'(dv), 32'd1);
      if (e.lat >= 0) chk($sformatf("dut%0d latency", d), 32'(cyc - e.fall), 32'(e.lat));
   endtask

   always @(negedge clk) if (cr0) mon(0, {1'b0, po0}, fe0, pe0, ov0, dv0);
   always @(negedge clk) if (cr1) mon(1, {2'b00, po1}, fe1, pe1, ov1, dv1);

   task automatic wait_ticks(input int n);
      int c = 0;
      while (c < n) begin
         @(posedge clk);
         if (tick) c++;
      end
   endtask

   task automatic set_line(input int d, input logic v);
      if (d == 0) line0 = v;
      else line1 = v;
   endtask

   task automatic drive(input int d, input logic v, input int os);
      set_line(d, v);
      wait_ticks(os);
      #1;
   endtask

   function automatic int os_of(input int d);
      return (d == 0) ? 16 : 8;
   endfunction

   // Sends one frame and queues the character the receiver must deliver for it.
   task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stops, input int lat, input bit same_ack,
                             input int brk);
      int   db  = (d == 0) ? 8 : 7;
      int   ns  = (d == 0) ? 1 : 2;
      bit   pen = (d == 1);
      int   os  = os_of(d);
      exp_t e;
      e.data = data & ((9'd1 << db) - 9'd1);
      e.perr = pen && ((($countones(e.data) + int'(pbit)) % 2) != 0);
      e.ferr = (ns == 1) ? !stops[0] : !(stops[0] && stops[1]);
      e.ovr  = same_ack ? 1'b0 : (model_ovr[d] | model_dv[d]);
      e.lat  = lat;
      model_dv[d]  = 1'b1;
      model_ovr[d] = e.ovr;
      @(posedge clk);
      #1;
      set_line(d, 1'b0);
      e.fall      = cyc;
      fall_cyc[d] = cyc;
      fall_seen[d] = 1'b1;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      wait_ticks(os);
      #1;
      for (int i = 0; i < db; i++) drive(d, data[i], os);
      if (pen) drive(d, pbit, os);
      for (int j = 0; j < ns; j++) drive(d, stops[j], os);
      repeat (brk) drive(d, 1'b0, os);
      set_line(d, 1'b1);
   endtask

   task automatic do_ack(input int d);
      @(posedge clk);
      #1;
      if (d == 0) ack0 = 1'b1;
      else ack1 = 1'b1;
      @(posedge clk);
      #1;
      ack0 = 1'b0;
      ack1 = 1'b0;
      model_dv[d]  = 1'b0;
      model_ovr[d] = 1'b0;
      chk($sformatf("dut%0d ack clears data_valid", d), 32'((d == 0) ? dv0 : dv1), 32'd0);
      chk($sformatf("dut%0d ack clears overrun", d), 32'((d == 0) ? ov0 : ov1), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL timeout: got no end of test, want completion within bound");
      $fatal(1, "timeout");
   end

   initial begin
      int p;
      int d;
      logic [8:0] rd;
      logic       pb;
      logic [1:0] st;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset parallel_out", 32'(po0), 32'd0);
      chk("reset data_valid", 32'(dv0), 32'd0);
      chk("reset char_received", 32'(cr0), 32'd0);
      chk("reset frame_err", 32'(fe0), 32'd0);
      chk("reset parity_err", 32'(pe0), 32'd0);
      chk("reset overrun", 32'(ov0), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);

      // default frame with start-to-pulse latency (152 clks + 3 for sync and start detect)
      send_frame(0, 9'h05A, 1'b0, 2'b11, 155, 1'b0, 0);
      wait_ticks(4);
      #1;
      chk("dut0 data_valid held", 32'(dv0), 32'd1);
      do_ack(0);

      // start-bit glitch
      p = npulse0;
      @(posedge clk);
      #1;
      line0 = 1'b0;
      wait_ticks(5);
      #1;
      line0 = 1'b1;
      wait_ticks(48);
      chk("glitch rejected", 32'(npulse0), 32'(p));

      // stop-bit error followed by a held-low break
      p = npulse0;
      send_frame(0, 9'h0A5, 1'b0, 2'b00, -1, 1'b0, 20);
      wait_ticks(32);
      chk("break delivers one char", 32'(npulse0), 32'(p + 1));
      do_ack(0);
      send_frame(0, 9'h03C, 1'b0, 2'b11, -1, 1'b0, 0);
      wait_ticks(16);
      chk("char after break", 32'(npulse0), 32'(p + 2));
      do_ack(0);

      // overrun, then acknowledge coinciding with completion
      send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0, 0);
      send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b0, 0);
      wait_ticks(8);
      do_ack(0);
      send_frame(0, 9'h033, 1'b0, 2'b11, -1, 1'b0, 0);
      send_frame(0, 9'h044, 1'b0, 2'b11, -1, 1'b0, 0);
      fall_seen[0] = 1'b0;
      fork
         send_frame(0, 9'h066, 1'b0, 2'b11, 155, 1'b1, 0);
         begin
            wait (fall_seen[0]);
            while (cyc != fall_cyc[0] + 154) begin
               @(posedge clk);
               #1;
            end
            ack0 = 1'b1;
            @(posedge clk);
            #1;
            ack0 = 1'b0;
         end
      join
      wait_ticks(4);
      #1;
      chk("same-clk ack keeps data_valid", 32'(dv0), 32'd1);
      chk("same-clk ack no overrun", 32'(ov0), 32'd0);
      do_ack(0);

      // even parity on the 7-bit instance
      send_frame(1, 9'h007, 1'b0, 2'b11, -1, 1'b0, 0);
      do_ack(1);
      send_frame(1, 9'h007, 1'b1, 2'b11, -1, 1'b0, 0);
      do_ack(1);

      // randomized frames on both instances
      for (int it = 0; it < 40; it++) begin
         d = $urandom_range(0, 1);
         tick_div = $urandom_range(1, 3);
         rd = 9'($urandom);
         pb = 1'($countones(rd[6:0]) % 2);
         if ($urandom_range(0, 3) == 0) pb = ~pb;
         st = 2'b11;
         if ($urandom_range(0, 7) == 0) st = 2'($urandom);
         send_frame(d, rd, pb, st, -1, 1'b0, 0);
         if ($urandom_range(0, 1) == 1) do_ack(d);
         wait_ticks(os_of(d) * $urandom_range(1, 2));
      end

      // reset during data bit 3 on the 7-bit instance with a slow tick
      tick_div = 4;
      wait_ticks(8);
      send_frame(1, 9'h02A, 1'b1, 2'b11, -1, 1'b0, 0);
      p = npulse1;
      @(posedge clk);
      #1;
      line1 = 1'b0;
      wait_ticks(8);
      #1;
      drive(1, 1'b1, 8);
      drive(1, 1'b0, 8);
      drive(1, 1'b1, 8);
      line1 = 1'b0;
      wait_ticks(4);
      #1;
      reset = 1'b1;
      line1 = 1'b1;
      #1;
      chk("mid-frame reset parallel_out", 32'(po1), 32'd0);
      chk("mid-frame reset data_valid", 32'(dv1), 32'd0);
      chk("mid-frame reset char_received", 32'(cr1), 32'd0);
      chk("mid-frame reset errors", 32'({fe1, pe1}), 32'd0);
      chk("mid-frame reset overrun", 32'(ov1), 32'd0);
      model_dv[0]  = 1'b0;
      model_ovr[0] = 1'b0;
      model_dv[1]  = 1'b0;
      model_ovr[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      wait_ticks(24);
      send_frame(1, 9'h055, 1'b0, 2'b11, -1, 1'b0, 0);
      wait_ticks(16);
      chk("frame after reset", 32'(npulse1), 32'(p + 1));

      chk("dut0 queue drained", 32'(q0.size()), 32'd0);
      chk("dut1 queue drained", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
